// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default constants for the data-memory bus arbiter and its
// address decoder.
package mem_bus_arbiter_pkg;

    // Address regions behind the shared slave bus
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_RTC  = 2'd1,
        REG_PLIC = 2'd2,
        REG_TB   = 2'd3
    } region_e;

    // Arbitration policy: fixed priority to master 0 or round-robin
    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Identity of a bus master
    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    // Default upper bounds (exclusive) of addr[31:28] for each region
    localparam logic [3:0] RAM_TOP_DEF  = 4'h2;
    localparam logic [3:0] RTC_TOP_DEF  = 4'h3;
    localparam logic [3:0] PLIC_TOP_DEF = 4'h8;

    // One-hot enable vector for a region: bit0 RAM, bit1 RTC, bit2 PLIC, bit3 TB
    function automatic logic [3:0] region_onehot(input region_e region);
        logic [3:0] onehot;
        case (region)
            REG_RAM:  onehot = 4'b0001;
            REG_RTC:  onehot = 4'b0010;
            REG_PLIC: onehot = 4'b0100;
            REG_TB:   onehot = 4'b1000;
            default:  onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two master request/return channels and the shared slave bus.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (core, DMA and the peripherals).
interface mem_bus_arbiter_if;

    logic        m0_en_i;
    logic [3:0]  m0_we_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_i;
    logic        m0_gnt_o;
    logic [31:0] m0_data_o;
    logic        m0_rvalid_o;

    logic        m1_en_i;
    logic [3:0]  m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic        m1_gnt_o;
    logic [31:0] m1_data_o;
    logic        m1_rvalid_o;

    logic        s_en_ram_o;
    logic        s_en_rtc_o;
    logic        s_en_plic_o;
    logic        s_en_tb_o;
    logic [3:0]  s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [31:0] s_ram_data_i;
    logic [31:0] s_rtc_data_i;
    logic [31:0] s_plic_data_i;
    logic [31:0] s_tb_data_i;

    modport slave (
        input  m0_en_i, m0_we_i, m0_addr_i, m0_data_i,
        output m0_gnt_o, m0_data_o, m0_rvalid_o,
        input  m1_en_i, m1_we_i, m1_addr_i, m1_data_i,
        output m1_gnt_o, m1_data_o, m1_rvalid_o,
        output s_en_ram_o, s_en_rtc_o, s_en_plic_o, s_en_tb_o,
        output s_we_o, s_addr_o, s_data_o,
        input  s_ram_data_i, s_rtc_data_i, s_plic_data_i, s_tb_data_i
    );

    modport master (
        output m0_en_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m0_gnt_o, m0_data_o, m0_rvalid_o,
        output m1_en_i, m1_we_i, m1_addr_i, m1_data_i,
        input  m1_gnt_o, m1_data_o, m1_rvalid_o,
        input  s_en_ram_o, s_en_rtc_o, s_en_plic_o, s_en_tb_o,
        input  s_we_o, s_addr_o, s_data_o,
        output s_ram_data_i, s_rtc_data_i, s_plic_data_i, s_tb_data_i
    );

endinterface

// File: rtl/mem_region_decode.sv
// Combinational region decoder: classifies the top address nibble into a
// region and produces one-hot region enables, gated by a valid qualifier.
module mem_region_decode
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [3:0] RAM_TOP  = RAM_TOP_DEF,
    parameter logic [3:0] RTC_TOP  = RTC_TOP_DEF,
    parameter logic [3:0] PLIC_TOP = PLIC_TOP_DEF
) (
    input  logic [3:0] i_addr_hi,
    input  logic       i_valid,
    output region_e    o_region,
    output logic [3:0] o_en_onehot
);

    // Classify the address nibble against the ascending region ceilings
    always_comb begin
        o_region = REG_TB;
        if (i_addr_hi < RAM_TOP) begin
            o_region = REG_RAM;
        end else if (i_addr_hi < RTC_TOP) begin
            o_region = REG_RTC;
        end else if (i_addr_hi < PLIC_TOP) begin
            o_region = REG_PLIC;
        end else begin
            o_region = REG_TB;
        end
    end

    // Expand the region into enables, all low when nothing is being accessed
    always_comb begin
        o_en_onehot = 4'b0000;
        if (i_valid) begin
            o_en_onehot = region_onehot(o_region);
        end else begin
            o_en_onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the data-memory slave bus. Grants one access per
// cycle, steers the winner onto the shared bus, and routes read data back to
// its owner one cycle later.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter arb_mode_e  ARB_MODE = ARB_FIXED,
    parameter logic [7:0] MAX_WAIT = 8'd8,      // 1..255
    parameter logic [3:0] RAM_TOP  = RAM_TOP_DEF,
    parameter logic [3:0] RTC_TOP  = RTC_TOP_DEF,
    parameter logic [3:0] PLIC_TOP = PLIC_TOP_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_bus_arbiter_if.slave  bus
);

    logic        w_m0_win;
    logic        w_m1_win;
    logic        w_any_win;
    logic [3:0]  w_s_we;
    logic [31:0] w_s_addr;
    logic [31:0] w_s_data;
    region_e     w_region;
    logic [3:0]  w_en_onehot;
    logic [31:0] w_rdata;

    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    owner_e      r_last_winner;
    owner_e      w_last_winner_nxt;

    logic        r_rd_pend;
    owner_e      r_owner;
    region_e     r_region;

    // Decide the winner; nobody wins while reset is asserted
    always_comb begin
        w_m0_win = 1'b0;
        w_m1_win = 1'b0;
        if (!reset_n) begin
            w_m0_win = 1'b0;
            w_m1_win = 1'b0;
        end else if (bus.m0_en_i && bus.m1_en_i) begin
            if (ARB_MODE == ARB_RR) begin
                w_m1_win = (r_last_winner == OWN_M0);
            end else begin
                // Starvation guard: m1 has been denied long enough
                w_m1_win = (r_wait_cnt == MAX_WAIT);
            end
            w_m0_win = ~w_m1_win;
        end else begin
            w_m0_win = bus.m0_en_i;
            w_m1_win = bus.m1_en_i;
        end
    end

    assign w_any_win = w_m0_win | w_m1_win;

    // Copy the winner's request onto the slave bus, zero when idle
    always_comb begin
        w_s_we   = 4'b0000;
        w_s_addr = 32'h0000_0000;
        w_s_data = 32'h0000_0000;
        if (w_m1_win) begin
            w_s_we   = bus.m1_we_i;
            w_s_addr = bus.m1_addr_i;
            w_s_data = bus.m1_data_i;
        end else if (w_m0_win) begin
            w_s_we   = bus.m0_we_i;
            w_s_addr = bus.m0_addr_i;
            w_s_data = bus.m0_data_i;
        end else begin
            w_s_we   = 4'b0000;
            w_s_addr = 32'h0000_0000;
            w_s_data = 32'h0000_0000;
        end
    end

    mem_region_decode #(
        .RAM_TOP  (RAM_TOP),
        .RTC_TOP  (RTC_TOP),
        .PLIC_TOP (PLIC_TOP)
    ) u_region_decode (
        .i_addr_hi   (w_s_addr[31:28]),
        .i_valid     (w_any_win),
        .o_region    (w_region),
        .o_en_onehot (w_en_onehot)
    );

    assign bus.m0_gnt_o    = w_m0_win;
    assign bus.m1_gnt_o    = w_m1_win;
    assign bus.s_we_o      = w_s_we;
    assign bus.s_addr_o    = w_s_addr;
    assign bus.s_data_o    = w_s_data;
    assign bus.s_en_ram_o  = w_en_onehot[0];
    assign bus.s_en_rtc_o  = w_en_onehot[1];
    assign bus.s_en_plic_o = w_en_onehot[2];
    assign bus.s_en_tb_o   = w_en_onehot[3];

    // Next arbitration state: m1 starvation counter and last granted master
    always_comb begin
        w_wait_cnt_nxt    = 8'd0;
        w_last_winner_nxt = r_last_winner;
        if ((ARB_MODE == ARB_FIXED) && bus.m1_en_i && !w_m1_win) begin
            if (r_wait_cnt >= MAX_WAIT) begin
                w_wait_cnt_nxt = MAX_WAIT;
            end else begin
                w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
        end else begin
            w_wait_cnt_nxt = 8'd0;
        end
        if (w_m1_win) begin
            w_last_winner_nxt = OWN_M1;
        end else if (w_m0_win) begin
            w_last_winner_nxt = OWN_M0;
        end else begin
            w_last_winner_nxt = r_last_winner;
        end
    end

    // Arbitration state register; m1 counts as last winner so m0 takes the first conflict
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wait_cnt    <= 8'd0;
            r_last_winner <= OWN_M1;
        end else begin
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_last_winner <= w_last_winner_nxt;
        end
    end

    // Remember a granted read so its data can be returned next cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_pend <= 1'b0;
            r_owner   <= OWN_M0;
            r_region  <= REG_RAM;
        end else begin
            r_rd_pend <= w_any_win && (w_s_we == 4'b0000);
            r_owner   <= w_m1_win ? OWN_M1 : OWN_M0;
            r_region  <= w_region;
        end
    end

    // Select the responding slave's data for the pending read
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (r_region)
            REG_RAM:  w_rdata = bus.s_ram_data_i;
            REG_RTC:  w_rdata = bus.s_rtc_data_i;
            REG_PLIC: w_rdata = bus.s_plic_data_i;
            REG_TB:   w_rdata = bus.s_tb_data_i;
            default:  w_rdata = 32'h0000_0000;
        endcase
    end

    assign bus.m0_rvalid_o = r_rd_pend && (r_owner == OWN_M0);
    assign bus.m1_rvalid_o = r_rd_pend && (r_owner == OWN_M1);
    assign bus.m0_data_o   = bus.m0_rvalid_o ? w_rdata : 32'h0000_0000;
    assign bus.m1_data_o   = bus.m1_rvalid_o ? w_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed-priority and a round-robin instance see
// the same stimulus and are compared every cycle against a behavioural model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus_fx ();
    mem_bus_arbiter_if bus_rr ();

    mem_bus_arbiter #(
        .ARB_MODE (ARB_FIXED), .MAX_WAIT (8'd8),
        .RAM_TOP (4'h2), .RTC_TOP (4'h3), .PLIC_TOP (4'h8)
    ) u_dut_fx (.clk (clk), .reset_n (reset_n), .bus (bus_fx.slave));

    mem_bus_arbiter #(
        .ARB_MODE (ARB_RR), .MAX_WAIT (8'd8),
        .RAM_TOP (4'h2), .RTC_TOP (4'h3), .PLIC_TOP (4'h8)
    ) u_dut_rr (.clk (clk), .reset_n (reset_n), .bus (bus_rr.slave));

    // shared stimulus
    logic        en0, en1;
    logic [3:0]  we0, we1;
    logic [31:0] ad0, ad1, dt0, dt1;
    logic [31:0] sd [4];

    assign bus_fx.m0_en_i = en0;   assign bus_rr.m0_en_i = en0;
    assign bus_fx.m0_we_i = we0;   assign bus_rr.m0_we_i = we0;
    assign bus_fx.m0_addr_i = ad0; assign bus_rr.m0_addr_i = ad0;
    assign bus_fx.m0_data_i = dt0; assign bus_rr.m0_data_i = dt0;
    assign bus_fx.m1_en_i = en1;   assign bus_rr.m1_en_i = en1;
    assign bus_fx.m1_we_i = we1;   assign bus_rr.m1_we_i = we1;
    assign bus_fx.m1_addr_i = ad1; assign bus_rr.m1_addr_i = ad1;
    assign bus_fx.m1_data_i = dt1; assign bus_rr.m1_data_i = dt1;
    assign bus_fx.s_ram_data_i = sd[0];  assign bus_rr.s_ram_data_i = sd[0];
    assign bus_fx.s_rtc_data_i = sd[1];  assign bus_rr.s_rtc_data_i = sd[1];
    assign bus_fx.s_plic_data_i = sd[2]; assign bus_rr.s_plic_data_i = sd[2];
    assign bus_fx.s_tb_data_i = sd[3];   assign bus_rr.s_tb_data_i = sd[3];

    // observed outputs, index 0 = fixed priority, 1 = round-robin
    logic [1:0]  ob_gnt [2];
    logic [3:0]  ob_en  [2];
    logic [3:0]  ob_we  [2];
    logic [31:0] ob_addr[2];
    logic [31:0] ob_wd  [2];
    logic [1:0]  ob_rv  [2];
    logic [31:0] ob_rd0 [2];
    logic [31:0] ob_rd1 [2];

    assign ob_gnt[0]  = {bus_fx.m1_gnt_o, bus_fx.m0_gnt_o};
    assign ob_en[0]   = {bus_fx.s_en_tb_o, bus_fx.s_en_plic_o, bus_fx.s_en_rtc_o, bus_fx.s_en_ram_o};
    assign ob_we[0]   = bus_fx.s_we_o;
    assign ob_addr[0] = bus_fx.s_addr_o;
    assign ob_wd[0]   = bus_fx.s_data_o;
    assign ob_rv[0]   = {bus_fx.m1_rvalid_o, bus_fx.m0_rvalid_o};
    assign ob_rd0[0]  = bus_fx.m0_data_o;
    assign ob_rd1[0]  = bus_fx.m1_data_o;
    assign ob_gnt[1]  = {bus_rr.m1_gnt_o, bus_rr.m0_gnt_o};
    assign ob_en[1]   = {bus_rr.s_en_tb_o, bus_rr.s_en_plic_o, bus_rr.s_en_rtc_o, bus_rr.s_en_ram_o};
    assign ob_we[1]   = bus_rr.s_we_o;
    assign ob_addr[1] = bus_rr.s_addr_o;
    assign ob_wd[1]   = bus_rr.s_data_o;
    assign ob_rv[1]   = {bus_rr.m1_rvalid_o, bus_rr.m0_rvalid_o};
    assign ob_rd0[1]  = bus_rr.m0_data_o;
    assign ob_rd1[1]  = bus_rr.m1_data_o;

    // reference model state
    int m_denied;          // consecutive cycles m1 asked and lost (fixed mode)
    int m_last;            // master granted most recently (round-robin)
    bit m_pend  [2];
    int m_owner [2];
    int m_region[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // region index from the address map: <0x2 RAM, <0x3 RTC, <0x8 PLIC, else TB
    function automatic int region_of(input logic [31:0] a);
        int hi;
        hi = int'(a >> 28);
        if (hi < 2) return 0;
        if (hi < 3) return 1;
        if (hi < 8) return 2;
        return 3;
    endfunction

    // -1 = no winner
    function automatic int exp_winner(input int d);
        if (reset_n !== 1'b1) return -1;
        if (en0 && en1) begin
            if (d == 0) return (m_denied >= MAXW) ? 1 : 0;
            return 1 - m_last;
        end
        if (en0) return 0;
        if (en1) return 1;
        return -1;
    endfunction

    task automatic check_dut(input int d, input int w);
        string p;
        logic [3:0]  e_en, e_we;
        logic [31:0] e_a, e_d, e_r0, e_r1;
        logic [1:0]  e_rv, e_g;
        p = (d == 0) ? "fx" : "rr";
        e_en = 4'b0000; e_we = 4'b0000; e_a = 32'd0; e_d = 32'd0;
        e_g  = 2'b00;
        if (w == 0) begin
            e_g = 2'b01; e_en = 4'b0001 << region_of(ad0); e_we = we0; e_a = ad0; e_d = dt0;
        end else if (w == 1) begin
            e_g = 2'b10; e_en = 4'b0001 << region_of(ad1); e_we = we1; e_a = ad1; e_d = dt1;
        end
        e_rv = 2'b00; e_r0 = 32'd0; e_r1 = 32'd0;
        if (m_pend[d]) begin
            if (m_owner[d] == 0) begin e_rv = 2'b01; e_r0 = sd[m_region[d]]; end
            else                 begin e_rv = 2'b10; e_r1 = sd[m_region[d]]; end
        end
        check_val({p, "_gnt"},    {30'd0, ob_gnt[d]}, {30'd0, e_g});
        check_val({p, "_en"},     {28'd0, ob_en[d]},  {28'd0, e_en});
        check_val({p, "_we"},     {28'd0, ob_we[d]},  {28'd0, e_we});
        check_val({p, "_addr"},   ob_addr[d], e_a);
        check_val({p, "_wdata"},  ob_wd[d],   e_d);
        check_val({p, "_rvalid"}, {30'd0, ob_rv[d]},  {30'd0, e_rv});
        check_val({p, "_m0data"}, ob_rd0[d],  e_r0);
        check_val({p, "_m1data"}, ob_rd1[d],  e_r1);
    endtask

    // one checked bus cycle; late_rst pulls reset low after the checks, before the edge
    task automatic do_cycle(input logic rst_in, input logic late_rst,
                            input logic e0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic e1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
        int win [2];
        @(negedge clk);
        reset_n = rst_in;
        en0 = e0; we0 = w0; ad0 = a0; dt0 = d0;
        en1 = e1; we1 = w1; ad1 = a1; dt1 = d1;
        for (int i = 0; i < 4; i++) sd[i] = $urandom();
        #1;
        for (int d = 0; d < 2; d++) begin
            win[d] = exp_winner(d);
            check_dut(d, win[d]);
        end
        if (late_rst) reset_n = 1'b0;
        @(posedge clk);
        if (reset_n !== 1'b1) begin
            m_denied = 0; m_last = 1;
            for (int d = 0; d < 2; d++) begin m_pend[d] = 1'b0; m_owner[d] = 0; m_region[d] = 0; end
        end else begin
            if (en1 && win[0] != 1) m_denied = (m_denied >= MAXW) ? MAXW : m_denied + 1;
            else                    m_denied = 0;
            if (win[1] >= 0) m_last = win[1];
            for (int d = 0; d < 2; d++) begin
                m_pend[d]   = (win[d] == 0 && we0 == 4'h0) || (win[d] == 1 && we1 == 4'h0);
                m_owner[d]  = (win[d] == 1) ? 1 : 0;
                m_region[d] = (win[d] == 1) ? region_of(ad1) : region_of(ad0);
            end
        end
    endtask

    task automatic rand_cycle();
        logic e0, e1, rst;
        logic [3:0] w0, w1;
        e0  = ($urandom_range(0, 3) != 0);
        e1  = ($urandom_range(0, 3) != 0);
        w0  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
        w1  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom());
        rst = ($urandom_range(0, 99) != 0);
        do_cycle(rst, ($urandom_range(0, 99) == 0), e0, w0, $urandom(), $urandom(),
                 e1, w1, $urandom(), $urandom());
    endtask

    initial begin
        m_denied = 0; m_last = 1;
        for (int d = 0; d < 2; d++) begin m_pend[d] = 1'b0; m_owner[d] = 0; m_region[d] = 0; end
        reset_n = 1'b0;
        en0 = 1'b1; en1 = 1'b1; we0 = 4'h0; we1 = 4'h0;
        ad0 = 32'h0; ad1 = 32'h0; dt0 = 32'h0; dt1 = 32'h0;
        for (int i = 0; i < 4; i++) sd[i] = 32'h0;
        @(posedge clk);
        // checked reset cycles with both masters requesting
        for (int i = 0; i < 2; i++)
            do_cycle(1'b0, 1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h1, 1'b1, 4'h0, 32'h8000_0000, 32'h2);
        // lone m0 read from RAM, then its return
        do_cycle(1'b1, 1'b0, 1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        // continuous contention: starvation guard vs alternation
        for (int i = 0; i < 30; i++)
            do_cycle(1'b1, 1'b0, 1'b1, 4'h0, 32'h2000_0000, 32'h0, 1'b1, 4'h0, 32'h8000_2000, 32'h0);
        // m0 write to TB window, no read return afterwards
        do_cycle(1'b1, 1'b0, 1'b1, 4'hF, 32'h8000_1000, 32'h0000_0041, 1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        // region boundaries, alternating masters back to back
        do_cycle(1'b1, 1'b0, 1'b1, 4'h0, 32'h1FFF_FFFC, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h2000_0000, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b1, 4'h0, 32'h7FFF_FFFC, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8000_0000, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        // m1 read granted, reset sampled at the following edge drops it
        do_cycle(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h3000_0000, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b1, 4'h0, 32'h3000_0000, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b1, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        // randomized traffic
        for (int i = 0; i < 600; i++) rand_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
